// File: rtl/sequence_generator_tx.sv
// sequence_generator_tx: serial frame transmitter for the 1011 sync-pattern link.
// Sends sync 1,0,1,1, then the payload MSB first, then an optional even-parity
// bit, then GAP_CYCLES idle zeros before the next word can be accepted.
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-low reset
//   data_in      payload word, captured on the valid/ready handshake
//   data_valid   upstream word available
//   data_ready   block can accept a word this cycle (from state register only)
//   sequence_out serial bit stream
//   bit_valid    sequence_out carries a sync, data or parity bit
//   frame_start  pulse with the first sync bit
//   frame_done   pulse with the last frame bit
//   busy         high from the first sync bit through the last gap cycle
module sequence_generator_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  sequence_out,
    output logic                  bit_valid,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic                  busy
);
    typedef enum logic [2:0] {IDLE, SYNC_A, SYNC_B, SYNC_C, SYNC_D, DATA, PARITY, GAP} state_t;
    localparam state_t     AFTER_PAR  = (GAP_CYCLES > 0) ? GAP : IDLE;
    localparam state_t     AFTER_DATA = (PARITY_EN != 0) ? PARITY : AFTER_PAR;
    localparam logic [4:0] DATA_LOAD  = 5'(DATA_WIDTH - 1);
    localparam logic [4:0] GAP_LOAD   = 5'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] shift, shift_next;
    logic [4:0]            cnt, cnt_next;
    logic                  parity, parity_next;
    logic                  seq_next, done_next;

    assign data_ready = (state == IDLE) && reset;

    // One counter serves both phases: it counts data bits in DATA and is
    // reloaded with the gap length on leaving DATA, then counts down in GAP.
    always_comb begin
        state_next  = state;
        shift_next  = shift;
        cnt_next    = cnt;
        parity_next = parity;
        case (state)
            IDLE: if (data_valid && data_ready) begin
                state_next  = SYNC_A;
                shift_next  = data_in;
                parity_next = ^data_in;
                cnt_next    = DATA_LOAD;
            end
            SYNC_A: state_next = SYNC_B;
            SYNC_B: state_next = SYNC_C;
            SYNC_C: state_next = SYNC_D;
            SYNC_D: state_next = DATA;
            DATA: begin
                shift_next = shift << 1;
                cnt_next   = cnt - 5'd1;
                if (cnt == 5'd0) begin
                    state_next = AFTER_DATA;
                    cnt_next   = GAP_LOAD;
                end
            end
            PARITY: state_next = AFTER_PAR;
            GAP: begin
                cnt_next = cnt - 5'd1;
                if (cnt == 5'd0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Outputs are registered from the next-state view so they line up
        // with the state occupied in the following cycle.
        seq_next  = (state_next inside {SYNC_A, SYNC_C, SYNC_D}) ||
                    (state_next == DATA && shift_next[DATA_WIDTH-1]) ||
                    (state_next == PARITY && parity_next);
        done_next = (PARITY_EN != 0) ? (state_next == PARITY)
                                     : (state_next == DATA && cnt_next == 5'd0);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            shift        <= '0;
            cnt          <= '0;
            parity       <= 1'b0;
            sequence_out <= 1'b0;
            bit_valid    <= 1'b0;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            shift        <= shift_next;
            cnt          <= cnt_next;
            parity       <= parity_next;
            sequence_out <= seq_next;
            bit_valid    <= (state_next != IDLE) && (state_next != GAP);
            frame_start  <= (state_next == SYNC_A);
            frame_done   <= done_next;
            busy         <= (state_next != IDLE);
        end
    end
endmodule

// File: tb/tb_sequence_generator_tx.sv
// tb_sequence_generator_tx: checks two configurations of the 1011 frame transmitter.
module tb_sequence_generator_tx;
    localparam int A_TOT = 4 + 8 + 1 + 2;
    localparam int B_TOT = 4 + 4 + 0 + 0;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] a_data = '0;
    logic       a_valid = 1'b0;
    logic [3:0] b_data = '0;
    logic       b_valid = 1'b0;
    logic a_ready, a_seq, a_bv, a_fs, a_fd, a_busy;
    logic b_ready, b_seq, b_bv, b_fs, b_fd, b_busy;
    int npass = 0;
    int ntotal = 0;
    int pa = -1;
    int pb = -1;
    logic [31:0] wa = '0;
    logic [31:0] wb = '0;

    always #5 clock = ~clock;

    sequence_generator_tx dut_a (
        .clock(clock), .reset(reset), .data_in(a_data), .data_valid(a_valid),
        .data_ready(a_ready), .sequence_out(a_seq), .bit_valid(a_bv),
        .frame_start(a_fs), .frame_done(a_fd), .busy(a_busy)
    );

    sequence_generator_tx #(.DATA_WIDTH(4), .PARITY_EN(0), .GAP_CYCLES(0)) dut_b (
        .clock(clock), .reset(reset), .data_in(b_data), .data_valid(b_valid),
        .data_ready(b_ready), .sequence_out(b_seq), .bit_valid(b_bv),
        .frame_start(b_fs), .frame_done(b_fd), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Expected {seq, bit_valid, frame_start, frame_done, busy} at frame position pos.
    function automatic logic [4:0] ent(input logic [31:0] w, input int W, input int P, input int pos);
        int L = 4 + W + P;
        logic [3:0] sy = 4'b1011;
        logic [31:0] m = (W == 32) ? '1 : ((32'd1 << W) - 32'd1);
        logic s;
        if (pos < 0) return 5'b00000;
        if (pos >= L) return 5'b00001;
        s = (pos < 4) ? sy[3-pos] : (pos < 4 + W) ? w[W-1-(pos-4)] : ^(w & m);
        return {s, 1'b1, pos == 0, pos == L - 1, 1'b1};
    endfunction

    // Model: position within the current frame+gap, -1 when idle.
    always @(posedge clock) begin
        if (!reset) begin
            pa = -1;
            pb = -1;
        end else begin
            if (pa < 0) begin
                if (a_valid) begin pa = 0; wa = 32'(a_data); end
            end else pa = (pa + 1 == A_TOT) ? -1 : pa + 1;
            if (pb < 0) begin
                if (b_valid) begin pb = 0; wb = 32'(b_data); end
            end else pb = (pb + 1 == B_TOT) ? -1 : pb + 1;
        end
    end

    always @(posedge clock) begin
        #1;
        chk("a_cycle", 32'({a_ready, a_seq, a_bv, a_fs, a_fd, a_busy}),
            32'({(pa < 0) && reset, ent(wa, 8, 1, pa)}));
        chk("b_cycle", 32'({b_ready, b_seq, b_bv, b_fs, b_fd, b_busy}),
            32'({(pb < 0) && reset, ent(wb, 4, 0, pb)}));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Waits for ready, presents d, returns #1 after the accepting edge.
    task automatic send(input bit which, input logic [7:0] d, input bit hold);
        int t = 0;
        while (!(which ? b_ready : a_ready) && t < 100) begin
            @(posedge clock); #1; t++;
        end
        chk("ready_wait", 32'(t < 100), 32'd1);
        if (which) begin b_data = d[3:0]; b_valid = 1'b1; end
        else begin a_data = d; a_valid = 1'b1; end
        @(posedge clock); #1;
        if (!hold) begin
            a_valid = 1'b0;
            b_valid = 1'b0;
            a_data = 8'($urandom);
            b_data = 4'($urandom);
        end
    endtask

    task automatic cap(input bit which, input int n, output logic [31:0] s,
                       output logic [31:0] bv, output logic [31:0] fs, output logic [31:0] fd);
        s = '0; bv = '0; fs = '0; fd = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clock); #1; end
            s  = {s[30:0],  which ? b_seq : a_seq};
            bv = {bv[30:0], which ? b_bv  : a_bv};
            fs = {fs[30:0], which ? b_fs  : a_fs};
            fd = {fd[30:0], which ? b_fd  : a_fd};
        end
    endtask

    logic [31:0] s, bv, fs, fd;

    initial begin
        a_valid = 1'b1;
        a_data  = 8'hA5;
        repeat (3) @(negedge clock);
        chk("reset_outputs", 32'({a_ready, a_seq, a_bv, a_fs, a_fd, a_busy}), 32'd0);
        reset = 1'b1;
        #1 chk("ready_after_release", 32'(a_ready), 32'd1);
        @(posedge clock); #1;
        a_valid = 1'b0;
        a_data  = 8'hFF;
        cap(0, 13, s, bv, fs, fd);
        chk("a5_stream", s, 32'b1011_10100101_0);
        chk("a5_start", fs, 32'b1_0000_0000_0000);
        chk("a5_done", fd, 32'd1);
        @(posedge clock); #1 chk("a5_gap1", 32'({a_seq, a_bv, a_busy, a_ready}), 32'b0010);
        @(posedge clock); #1 chk("a5_gap2", 32'({a_seq, a_bv, a_busy, a_ready}), 32'b0010);
        @(posedge clock); #1 chk("a5_ready_k16", 32'({a_busy, a_ready}), 32'b01);

        send(0, 8'h0B, 0);
        cap(0, 13, s, bv, fs, fd);
        chk("0b_stream", s, 32'b1011_00001011_1);

        send(0, 8'h3C, 1);
        a_data = 8'hC3;
        cap(0, 13, s, bv, fs, fd);
        chk("3c_stream", s, 32'b1011_00111100_0);
        @(posedge clock); #1 chk("hold_gap1", 32'({a_seq, a_bv, a_ready}), 32'b000);
        @(posedge clock); #1 chk("hold_gap2", 32'({a_seq, a_bv, a_ready}), 32'b000);
        @(posedge clock); #1 chk("hold_idle", 32'({a_bv, a_ready}), 32'b01);
        @(posedge clock); #1;
        a_valid = 1'b0;
        cap(0, 13, s, bv, fs, fd);
        chk("c3_stream", s, 32'b1011_11000011_0);
        chk("c3_done", fd, 32'd1);

        send(0, 8'h96, 0);
        cap(0, 7, s, bv, fs, fd);
        chk("abort_prefix", s, 32'b1011_100);
        @(negedge clock) reset = 1'b0;
        @(posedge clock); #1;
        chk("abort_outputs", 32'({a_ready, a_seq, a_bv, a_fs, a_fd, a_busy}), 32'd0);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1 chk("abort_no_done", 32'({a_fd, a_bv, a_busy}), 32'd0);
        send(0, 8'h5A, 0);
        cap(0, 13, s, bv, fs, fd);
        chk("fresh_stream", s, 32'b1011_01011010_0);
        chk("fresh_start", fs, 32'b1_0000_0000_0000);

        send(1, 8'h09, 0);
        cap(1, 8, s, bv, fs, fd);
        chk("b_stream", s, 32'b1011_1001);
        chk("b_done", fd, 32'd1);
        @(posedge clock); #1 chk("b_ready_after", 32'({b_bv, b_ready}), 32'b01);

        send(1, 8'h09, 1);
        cap(1, 17, s, bv, fs, fd);
        b_valid = 1'b0;
        chk("b2b_stream", s, 32'b1011_1001_0_1011_1001);
        chk("b2b_valid", bv, 32'b1111_1111_0_1111_1111);
        chk("b2b_start", fs, 32'b1000_0000_0_1000_0000);

        repeat (20) @(posedge clock);
        #2;
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule

// File: doc/sequence_generator_tx.md
Name: sequence_generator_tx

Overview:
- Serial frame transmitter for the "1011" sync-pattern serial link. It is the sending end matching the 1011 sequence detector.
- Accepts a parallel payload word over a valid/ready handshake.
- Emits one bit per clock on sequence_out: the sync pattern 1,0,1,1, then the payload MSB-first, then an optional even-parity bit, then an idle gap of zeros.
- Sits upstream of the detector and drives test/link traffic into it.

Parameters:
- DATA_WIDTH, 8: payload bits per frame (legal range 1..32).
- PARITY_EN, 1: 1 = append one even-parity bit after the payload; 0 = no parity bit.
- GAP_CYCLES, 2: idle zero cycles after each frame before a new word is accepted (legal range 0..15).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset); one clock, reset is synchronous and active-low.
- data_in  input  DATA_WIDTH  payload word, sampled on handshake.
- data_valid  input  1  upstream word available.
- data_ready  output  1  block can accept a word this cycle.
- sequence_out  output  1  serial bit stream.
- bit_valid  output  1  sequence_out carries a frame bit (sync, data or parity).
- frame_start  output  1  one-cycle pulse aligned with the first sync bit.
- frame_done  output  1  one-cycle pulse aligned with the last frame bit.
- busy  output  1  high from the first sync bit through the last gap cycle.

Behaviour:
- All outputs except data_ready are registered.
- data_ready = (state==IDLE) && reset. It is combinational from the state register only, never from data_valid.
- Reset (reset==0 at a rising edge):
  - state<=IDLE.
  - sequence_out, bit_valid, frame_start, frame_done, busy <= 0.
  - Shift register, bit counter and parity accumulator cleared.
  - Reset mid-frame aborts the frame immediately: no partial bits after the reset edge, no frame_done.
  - The first accept is possible at the first edge after reset returns to 1.
- Handshake:
  - A word is accepted at edge k when data_valid && data_ready.
  - data_in is latched into the shift register; parity = XOR of data_in.
  - data_valid while not ready is ignored; it is neither queued nor lost-tracked.
  - data_in may change freely after acceptance.
- States: IDLE -> SYNC_A -> SYNC_B -> SYNC_C -> SYNC_D -> DATA -> PARITY (only if PARITY_EN) -> GAP (only if GAP_CYCLES>0) -> IDLE.
- Sync bits:
  - SYNC_A..SYNC_D drive sequence_out = 1,0,1,1 respectively.
  - SYNC_A is the cycle after edge k (latency 1), with frame_start=1 in that cycle.
- DATA:
  - DATA_WIDTH cycles, MSB first, via a left shift.
  - A counter counts DATA_WIDTH-1 down to 0; exit to the next state when it reaches 0.
- PARITY: one cycle, sequence_out = even-parity bit, so the total ones in payload+parity is even.
- Frame length L = 4 + DATA_WIDTH + PARITY_EN cycles. bit_valid=1 and busy=1 for all L cycles. frame_done=1 in the L-th cycle only.
- GAP:
  - GAP_CYCLES cycles with sequence_out=0, bit_valid=0, busy=1.
  - Then IDLE: data_ready rises in the cycle after the last gap cycle.
  - With GAP_CYCLES=0, IDLE directly follows the last frame bit, giving a minimum accept-to-accept spacing of L+1 edges.
- IDLE: sequence_out=0, bit_valid=0, busy=0.
- Payload values containing 1011 are transmitted unmodified. There is no bit stuffing; framing ambiguity is the receiver's concern.
- Illegal/unused state encodings return to IDLE with all outputs 0.

Test Plan:
- Reset held low for 3 cycles with data_valid=1 -> all outputs 0, data_ready=0, no accept. Release -> data_ready=1 on the next cycle.
- Defaults, data_in=8'hA5 accepted at edge k:
  - sequence_out over cycles k+1..k+13 = 1011 10100101 0.
  - frame_start at k+1, frame_done at k+13.
  - Two gap cycles of 0, then data_ready=1 at k+16.
- data_in=8'h0B (payload contains 1011) -> stream 1011 00001011 1. The parity bit is 1 (three ones), and the payload is sent unaltered.
- data_valid held high continuously with 8'h3C then 8'hC3 -> second word accepted only when data_ready returns. Exactly two frames appear, each 13 bits with correct parity (0 and 0), separated by 2 zero gap cycles.
- reset driven low during payload bit 3 of a frame -> outputs 0 on the next cycle, no frame_done. The next accepted word produces a complete fresh frame starting with 1011.
- PARITY_EN=0, GAP_CYCLES=0, DATA_WIDTH=4:
  - data_in=4'b1001 -> 8-bit frame 1011 1001.
  - frame_done on bit 8; data_ready=1 the following cycle.
  - Back-to-back accept gives 1011 1001 1011 ... with no zero gap cycles, and bit_valid low only for the one IDLE cycle between frames.
